// File: rtl/alu_addsub_sequencer.sv
// alu_addsub_sequencer
// Front-end and result stage for an external WIDTH-bit adder-subtractor.
// One operation is accepted in IDLE and its operands are registered straight
// onto the as_* outputs. The external adder is given one EXEC cycle. Its
// sum/carry are then captured together with locally computed flags. The
// result is held in HOLD until the consumer takes it.
//
// Both handshakes use the same valid/ready rule. A transfer happens on a rising
// edge where valid and ready are both 1. A source holding valid must keep its
// payload stable until that edge. Ready never depends combinationally on
// valid.
//
// in_ready and out_valid are registered from the next-state decode. This keeps
// them 0 while reset is asserted, and they stay consistent with the state
// register.
module alu_addsub_sequencer #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] as_a,
    output logic [WIDTH-1:0] as_b,
    output logic             as_sel,
    input  logic [WIDTH-1:0] as_sum,
    input  logic             as_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_ACC = 2'd2;
    localparam logic [1:0] OP_CLR = 2'd3;

    state_t           state;
    state_t           next_state;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] acc;
    logic             accept;
    logic             ovf;

    assign accept    = in_valid & in_ready;
    assign dbg_state = state;

    // Next-state decode; EXEC always lasts exactly one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = EXEC;
            EXEC:    next_state = HOLD;
            HOLD:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Signed overflow from operand and result sign bits. The subtract rule
    // uses the uninverted B, which is the operand the requester supplied.
    always_comb begin
        ovf = 1'b0;
        if (op_reg == OP_SUB) begin
            ovf = (as_a[WIDTH-1] != as_b[WIDTH-1]) && (as_sum[WIDTH-1] != as_a[WIDTH-1]);
        end else begin
            ovf = (as_a[WIDTH-1] == as_b[WIDTH-1]) && (as_sum[WIDTH-1] != as_a[WIDTH-1]);
        end
    end

    // State register plus registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == HOLD);
        end
    end

    // Operand capture on accept. The as_* outputs are these registers, and
    // they hold their value outside EXEC. ACC takes the accumulator as A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg <= OP_ADD;
            as_a   <= '0;
            as_b   <= '0;
            as_sel <= 1'b0;
        end else if (state == IDLE && accept) begin
            op_reg <= in_op;
            as_a   <= (in_op == OP_ACC) ? acc : in_a;
            as_b   <= in_b;
            as_sel <= (in_op == OP_SUB);
        end
    end

    // Result and accumulator capture at the EXEC->HOLD edge. CLR ignores the
    // adder and loads the init value everywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= ACC_INIT;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
            out_neg   <= 1'b0;
        end else if (state == EXEC) begin
            if (op_reg == OP_CLR) begin
                acc       <= ACC_INIT;
                out_sum   <= ACC_INIT;
                out_carry <= 1'b0;
                out_ovf   <= 1'b0;
                out_zero  <= (ACC_INIT == '0);
                out_neg   <= ACC_INIT[WIDTH-1];
            end else begin
                acc       <= as_sum;
                out_sum   <= as_sum;
                out_carry <= as_carry;
                out_ovf   <= ovf;
                out_zero  <= (as_sum == '0);
                out_neg   <= as_sum[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_addsub_sequencer.sv
// tb_alu_addsub_sequencer
// Table-driven vectors, hand-written multi-cycle sequences and random ops.
// A behavioural adder-subtractor sits on the as_* port. Expected results go to
// a queue when a request is issued, and they are popped when the result is
// taken.
module tb_alu_addsub_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_op = 2'd0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] as_a;
    logic [W-1:0] as_b;
    logic         as_sel;
    logic [W-1:0] as_sum;
    logic         as_carry;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_ovf;
    logic         out_zero;
    logic         out_neg;
    logic [1:0]   dbg_state;

    alu_addsub_sequencer #(.WIDTH(W), .ACC_INIT(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .as_a(as_a), .as_b(as_b), .as_sel(as_sel),
        .as_sum(as_sum), .as_carry(as_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_neg(out_neg), .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Behavioural adder-subtractor: subtract is A + ~B + 1, so carry=1 means no borrow.
    logic [W:0] adder_full;
    assign adder_full = as_sel ? ({1'b0, as_a} + {1'b0, ~as_b} + 17'd1)
                               : ({1'b0, as_a} + {1'b0, as_b});
    assign as_sum   = adder_full[W-1:0];
    assign as_carry = adder_full[W];

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         c;
        logic         o;
        logic         z;
        logic         n;
    } vec_t;

    vec_t         vecs[12];
    logic [W+3:0] exp_q[$];
    logic [W-1:0] model_acc;
    int           n_checks = 0;
    int           n_fail = 0;

    // Scoreboard helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W+3:0] pack_vec(input vec_t v);
        return {v.c, v.o, v.z, v.n, v.sum};
    endfunction

    // Reference model in integer arithmetic: {carry, ovf, zero, neg, sum}
    function automatic logic [W+3:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] acc);
        logic [W-1:0] x;
        logic [W-1:0] s;
        logic [W:0]   full;
        logic         c;
        logic         o;
        int           xs;
        int           ys;
        int           r;
        s = '0;
        c = 1'b0;
        o = 1'b0;
        if (op != 2'd3) begin
            x  = (op == 2'd2) ? acc : a;
            xs = int'($signed(x));
            ys = int'($signed(b));
            if (op == 2'd1) begin
                full = {1'b0, x} - {1'b0, b};
                c    = (x >= b);
                r    = xs - ys;
            end else begin
                full = {1'b0, x} + {1'b0, b};
                c    = full[W];
                r    = xs + ys;
            end
            s = full[W-1:0];
            o = (r > 32767) || (r < -32768);
        end
        return {c, o, (s == '0), s[W-1], s};
    endfunction

    // Driver: present a request, wait for accept, then check the EXEC cycle.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W+3:0] expv);
        int cnt;
        logic [W-1:0] exp_a;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        cnt      = 0;
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("accept_timeout", {31'd0, in_ready}, 32'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(expv);
        exp_a = (op == 2'd2) ? model_acc : a;
        @(negedge clk);
        in_valid = 1'b0;
        check("exec_in_ready", {31'd0, in_ready}, 32'd0);
        check("exec_out_valid", {31'd0, out_valid}, 32'd0);
        check("exec_as_sel", {31'd0, as_sel}, {31'd0, (op == 2'd1)});
        if (op != 2'd3) begin
            check("exec_as_a", {16'd0, as_a}, {16'd0, exp_a});
            check("exec_as_b", {16'd0, as_b}, {16'd0, b});
        end
        model_acc = (op == 2'd3) ? 16'h0000 : model(op, a, b, model_acc)[W-1:0];
    endtask

    // Take one result; out_valid must already be up on the cycle after EXEC.
    task automatic collect();
        logic [W+3:0] e;
        @(negedge clk);
        check("hold_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        if (exp_q.size() == 0) begin
            check("queue_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("result", {12'd0, out_carry, out_ovf, out_zero, out_neg, out_sum}, {12'd0, e});
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // op, a, b, sum, carry, ovf, zero, neg
        vecs[0]  = '{2'd3, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{2'd2, 16'h0000, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'd2, 16'h0000, 16'h0007, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{2'd2, 16'h0000, 16'hFFF4, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{2'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{2'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{2'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{2'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{2'd2, 16'h0000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{2'd0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{2'd3, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{2'd2, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        model_acc = 16'h0000;

        // Reset state: every output 0 while reset is held.
        #1;
        check("rst_outputs", {in_ready, out_valid, as_sel, out_carry, out_ovf, out_zero, out_neg, 25'd0},
              32'd0);
        check("rst_data", {as_a, out_sum}, 32'd0);
        check("rst_as_b", {16'd0, as_b}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, pack_vec(vecs[i]));
            collect();
        end

        // Reset mid-EXEC discards the op and reverts the accumulator.
        issue(2'd0, 16'h0100, 16'h0200, model(2'd0, 16'h0100, 16'h0200, model_acc));
        collect();
        issue(2'd2, 16'h0000, 16'h0001, model(2'd2, 16'h0000, 16'h0001, model_acc));
        check("pre_reset_state_exec", {30'd0, dbg_state}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_flags", {in_ready, out_valid, as_sel, out_carry, out_ovf, out_zero, out_neg, 25'd0},
              32'd0);
        check("midrst_data", {as_a, out_sum}, 32'd0);
        check("midrst_as_b", {16'd0, as_b}, 32'd0);
        exp_q.delete();
        model_acc = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'd2, 16'h5555, 16'h0000, model(2'd2, 16'h5555, 16'h0000, model_acc));
        collect();

        // Backpressure: result held, new request waits, accepted one cycle after release.
        issue(2'd0, 16'h0001, 16'h0002, model(2'd0, 16'h0001, 16'h0002, model_acc));
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'd0;
        in_a     = 16'h0003;
        in_b     = 16'h0004;
        for (int i = 0; i < 10; i++) begin
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_sum", {16'd0, out_sum}, 32'd3);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("bp_result", {12'd0, out_carry, out_ovf, out_zero, out_neg, out_sum}, {12'd0, exp_q.pop_front()});
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(model(2'd0, 16'h0003, 16'h0004, model_acc));
        model_acc = 16'h0007;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accept_exec", {30'd0, dbg_state}, 32'd1);
        check("bp_exec_as_a", {16'd0, as_a}, 32'd3);
        collect();

        // Random ops checked against the model
        for (int i = 0; i < 24; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom_range(0, 65535));
            b  = 16'($urandom_range(0, 65535));
            issue(op, a, b, model(op, a, b, model_acc));
            collect();
        end

        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
